// File: rtl/sum_frame_accumulator_if.sv
// Handshake bundle for sum_frame_accumulator.
//   master: upstream sample source plus downstream result sink (drives
//           in_data/in_valid/out_ready, observes in_ready/out_*).
//   slave : the accumulator itself.
interface sum_frame_accumulator_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/sum_frame_accumulator.sv
// Totals FRAME_LEN unsigned DATA_W-bit samples into an ACC_W-bit result with a
// sticky per-frame overflow flag, and holds each total on a registered
// valid/ready output until it is accepted.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of sum_frame_accumulator_if (sample in, total out)
//   busy   - a partial frame is in progress
module sum_frame_accumulator #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sum_frame_accumulator_if.slave        bus,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_acc;
  logic             in_xfer;
  logic [ACC_W:0]   sum_next;

  assign bus.in_ready = (state != HOLD);
  assign busy         = (state == ACC);
  assign in_xfer      = bus.in_valid & bus.in_ready;

  // Extra MSB of sum_next is the carry out of the ACC_W-bit accumulator.
  assign sum_next = {1'b0, acc} + (ACC_W + 1)'(bus.in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf_acc       <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_xfer) begin
            acc     <= ACC_W'(bus.in_data);
            ovf_acc <= 1'b0;
            cnt     <= 8'd1;
            state   <= ACC;
          end
        end
        ACC: begin
          if (in_xfer) begin
            acc     <= sum_next[ACC_W-1:0];
            ovf_acc <= ovf_acc | sum_next[ACC_W];
            if (cnt == 8'(FRAME_LEN - 1)) begin
              bus.out_sum   <= sum_next[ACC_W-1:0];
              bus.out_ovf   <= ovf_acc | sum_next[ACC_W];
              bus.out_valid <= 1'b1;
              cnt           <= '0;
              state         <= HOLD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Scoreboard bench: two accumulators (ACC_W=6 and ACC_W=5) share one input
// stream; a cycle model predicts handshake state and pushes each wide frame
// total, which is reduced per width when the result is presented.
module tb_sum_frame_accumulator;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned FRAME_LEN = 4;

  logic clk;
  logic rst_n;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic out_ready;
  logic busy6, busy5;

  int checks   = 0;
  int failures = 0;

  sum_frame_accumulator_if #(.DATA_W(DATA_W), .ACC_W(6)) bus6 ();
  sum_frame_accumulator_if #(.DATA_W(DATA_W), .ACC_W(5)) bus5 ();

  assign bus6.in_data   = in_data;
  assign bus6.in_valid  = in_valid;
  assign bus6.out_ready = out_ready;
  assign bus5.in_data   = in_data;
  assign bus5.in_valid  = in_valid;
  assign bus5.out_ready = out_ready;

  sum_frame_accumulator #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(6)) dut6 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus6),
    .busy (busy6)
  );

  sum_frame_accumulator #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(5)) dut5 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus5),
    .busy (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  int m_cnt;
  int m_sum;
  bit m_hold;
  int qexp[$];
  int frames_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_sum  <= 0;
      m_hold <= 1'b0;
      qexp.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold <= 1'b0;
        void'(qexp.pop_front());
        frames_done <= frames_done + 1;
      end
    end else if (in_valid) begin
      if (m_cnt == FRAME_LEN - 1) begin
        qexp.push_back(m_sum + int'(in_data));
        m_hold <= 1'b1;
        m_cnt  <= 0;
        m_sum  <= 0;
      end else begin
        m_sum <= m_sum + int'(in_data);
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready6", int'(bus6.in_ready), int'(!m_hold));
      chk("in_ready5", int'(bus5.in_ready), int'(!m_hold));
      chk("out_valid6", int'(bus6.out_valid), int'(m_hold));
      chk("out_valid5", int'(bus5.out_valid), int'(m_hold));
      chk("busy6", int'(busy6), int'(m_cnt != 0 && !m_hold));
      chk("busy5", int'(busy5), int'(m_cnt != 0 && !m_hold));
      if (m_hold && qexp.size() > 0) begin
        chk("out_sum6", int'(bus6.out_sum), qexp[0] % 64);
        chk("out_ovf6", int'(bus6.out_ovf), int'(qexp[0] > 63));
        chk("out_sum5", int'(bus5.out_sum), qexp[0] % 32);
        chk("out_ovf5", int'(bus5.out_ovf), int'(qexp[0] > 31));
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus6.in_ready;
      @(posedge clk);
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    frames_done = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // basic frame: 3+9+1+15 = 28
    send(4'd3); send(4'd9); send(4'd1); send(4'd15);
    idle(3);

    // async reset mid-cycle with a retained non-zero result
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_sum6", int'(bus6.out_sum), 0);
    chk("rst_out_ovf5", int'(bus5.out_ovf), 0);
    chk("rst_out_valid6", int'(bus6.out_valid), 0);
    chk("rst_in_ready6", int'(bus6.in_ready), 1);
    chk("rst_busy6", int'(busy6), 0);
    #2 rst_n = 1'b1;
    idle(1);

    // overflow on the 5-bit instance, then a clean frame
    send(4'd15); send(4'd15); send(4'd15); send(4'd15);
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    idle(2);

    // backpressure: result held 5 cycles, pending 7 starts the next frame
    out_ready = 1'b0;
    send(4'd10); send(4'd11); send(4'd12); send(4'd13);
    fork
      send(4'd7);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(4'd1); send(4'd2); send(4'd3);
    idle(2);

    // valid gaps inside a frame: 2+4+6+8 = 20
    send(4'd2); idle(2); send(4'd4); idle(1); send(4'd6); send(4'd8);
    idle(2);

    // reset mid-frame discards 5,5
    send(4'd5); send(4'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idle(1);
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    idle(3);

    chk("frames_done", frames_done, 7);
    chk("queue_empty", qexp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
